harmonic_scale_seq: RTL and testbench
=====================================

Name: harmonic_scale_seq

Overview:
Generates the per-harmonic amplitude multiplier for the additive oscillator. It is stepped once per harmonic by the harmonic sequencer and restarted at each sample frame. It extends the single-scale attenuator with:
- separate odd/even attenuation slopes
- a harmonic index output
- exhausted (zero-amplitude) detection
- a fixed-latency ready handshake
- parametrised multiplier, index and comb widths

Parameters:
DIV_BIT, 8, width of multiplier, initial value and scale inputs
HARM_BIT, 8, width of harmonic index; the index saturates at 2^HARM_BIT-1
COMB_BIT, 8, width of comb interval and comb counter

Ports:
i_Clock  in  1  system clock; all logic is rising-edge
i_Reset_n  in  1  asynchronous, active-low reset
i_Restart  in  1  synchronous frame restart; reloads the initial value
i_Start  in  1  request for the next harmonic's multiplier
i_Initial  in  DIV_BIT  multiplier for harmonic 0
i_Scale_Odd  in  DIV_BIT  attenuation step applied when the new index is odd
i_Scale_Even  in  DIV_BIT  attenuation step applied when the new index is even
i_Comb_Interval  in  COMB_BIT  comb period; 0 disables the comb
o_Mult  out  DIV_BIT  current multiplier
o_Harmonic  out  HARM_BIT  index of the harmonic o_Mult belongs to
o_Comb_Muted  out  1  current harmonic is comb-muted
o_Exhausted  out  1  o_Mult == 0; combinational from the o_Mult register
o_Mult_Ready  out  1  outputs valid; the block accepts i_Start

Behaviour:
- Async reset (i_Reset_n=0): o_Mult=0, o_Harmonic=0, o_Comb_Muted=0, o_Mult_Ready=1, comb counter=0, state=ST_READY.
- i_Restart (synchronous) has priority over everything, in any state:
  - o_Mult<=i_Initial, o_Harmonic<=0, comb counter<=0, o_Comb_Muted<=0, o_Mult_Ready<=1, state<=ST_READY.
  - Any step in flight is aborted.
- ST_READY:
  - i_Start is sampled only here; i_Start in any other state is ignored, not queued.
  - On i_Start: o_Mult_Ready<=0, o_Comb_Muted<=0, latch next index n=o_Harmonic+1 (held at max if already saturated), state<=ST_CALC.
- ST_CALC:
  - Step S = i_Scale_Odd if n[0] else i_Scale_Even.
  - o_Mult<=o_Mult-S when o_Mult>=S, else 0 (saturating).
  - o_Harmonic<=n.
  - Comb evaluation (below).
  - state<=ST_DONE.
- Comb evaluation:
  - If i_Comb_Interval==0: counter held at 0, no muting.
  - Else if counter==i_Comb_Interval: o_Comb_Muted<=1, counter<=0.
  - Else counter<=counter+1.
- ST_DONE: o_Mult_Ready<=1, state<=ST_READY.
- Latency: i_Start sampled at edge k. o_Mult_Ready is low after edge k and high again after edge k+2. New outputs are stable from edge k+2. Maximum throughput is one step per 3 cycles.
- Once o_Mult reaches 0 it stays 0 until restart; o_Exhausted lets the sequencer skip the remaining harmonics.
- i_Comb_Interval changed mid-frame: takes effect at the next comparison. A counter above the new interval keeps incrementing and wraps at 2^COMB_BIT.
- Restart and Start in the same cycle: restart wins and the start is dropped.

Optional Feature:
Macro HARM_SCALE_EXP_EN.
- Defined: exponential decay.
  - Adds state ST_MUL between ST_READY and ST_CALC, which registers P=(o_Mult*S)>>DIV_BIT.
  - ST_CALC subtracts max(P,1) when o_Mult>0, guaranteeing monotonic decay to 0.
  - Latency becomes 3 cycles; the Start-to-ready rise is edge k+3.
- Undefined: linear saturating subtract as above; no multiplier is inferred.

Decomposition:
- Package harmonic_scale_pkg: state encodings ST_READY, ST_MUL, ST_CALC, ST_DONE (2-bit) and the saturating-subtract function.
- Sub-module harmonic_comb_ctr: comb counter and mute decision. Inputs: step strobe, clear, interval. Output: mute pulse.

Test Plan:
- Reset, restart with Initial=200, Odd=10, Even=30, Comb=0, four starts -> o_Mult 190,160,150,120; o_Harmonic 1..4; Muted always 0.
- Initial=25, Odd=Even=10, five starts -> 15,5,0,0,0; o_Exhausted=1 from step 3.
- Comb=2, six starts -> Muted pattern 0,0,1,0,0,1; counter returns to 0 after each mute.
- Start held high continuously -> Ready low exactly 2 cycles per step (3 with HARM_SCALE_EXP_EN); one step accepted per Ready-high cycle; extra pulses ignored.
- Restart asserted in ST_CALC, and Restart with Start in the same cycle -> o_Mult=i_Initial, o_Harmonic=0, Ready=1 the next cycle; no step is applied.
- HARM_SCALE_EXP_EN, Initial=128, Scale=64 (DIV_BIT=8) -> 96,72,54,41 over four steps; with Scale=1 the multiplier still decrements by 1 per step.

Source files
------------

// File: rtl/harmonic_scale_pkg.sv
// Shared definitions for the harmonic amplitude sequencer: the FSM state
// encoding and the saturating subtract used to attenuate the multiplier.
package harmonic_scale_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_MUL   = 2'd1,
    ST_CALC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Working width of sat_sub; callers zero-extend into it and truncate back.
  localparam int SUB_BIT = 32;

  // a - b clamped at zero, so the multiplier never wraps around.
  function automatic logic [SUB_BIT-1:0] sat_sub(input logic [SUB_BIT-1:0] a,
                                                 input logic [SUB_BIT-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/harmonic_comb_ctr.sv
// Comb counter: counts harmonic steps and flags every (interval+1)-th step
// as muted. An interval of zero disables the comb and parks the counter.
module harmonic_comb_ctr #(
  parameter int COMB_BIT = 8
) (
  input  logic                i_Clock,
  input  logic                i_Reset_n,
  input  logic                i_Step,
  input  logic                i_Clear,
  input  logic [COMB_BIT-1:0] i_Interval,
  output logic                o_Mute
);

  logic [COMB_BIT-1:0] count;

  // Mute decision for the step being evaluated right now.
  assign o_Mute = i_Step && (i_Interval != '0) && (count == i_Interval);

  // Counter advances per step, restarts after a mute, and wraps naturally
  // if the interval was lowered below the current count.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count <= '0;
    end else if (i_Clear) begin
      count <= '0;
    end else if (i_Step) begin
      if (i_Interval == '0) begin
        count <= '0;
      end else if (count == i_Interval) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/harmonic_scale_seq.sv
// Per-harmonic amplitude multiplier generator for the additive oscillator.
// Stepped once per harmonic, restarted every sample frame. Odd/even harmonics
// use separate attenuation steps; a comb can mute every Nth harmonic.
// Optional macro HARM_SCALE_EXP_EN: exponential decay (subtract a fraction of
// the current multiplier) through an extra ST_MUL state; otherwise a linear
// saturating subtract with no multiplier.
module harmonic_scale_seq
  import harmonic_scale_pkg::*;
#(
  parameter int DIV_BIT  = 8,
  parameter int HARM_BIT = 8,
  parameter int COMB_BIT = 8
) (
  input  logic                i_Clock,
  input  logic                i_Reset_n,
  input  logic                i_Restart,
  input  logic                i_Start,
  input  logic [DIV_BIT-1:0]  i_Initial,
  input  logic [DIV_BIT-1:0]  i_Scale_Odd,
  input  logic [DIV_BIT-1:0]  i_Scale_Even,
  input  logic [COMB_BIT-1:0] i_Comb_Interval,
  output logic [DIV_BIT-1:0]  o_Mult,
  output logic [HARM_BIT-1:0] o_Harmonic,
  output logic                o_Comb_Muted,
  output logic                o_Exhausted,
  output logic                o_Mult_Ready
);

  localparam logic [HARM_BIT-1:0] HARM_MAX = '1;

  state_t              state;
  state_t              state_next;
  logic [HARM_BIT-1:0] next_idx;
  logic [DIV_BIT-1:0]  step_sel;
  logic [DIV_BIT-1:0]  sub_amt;
  logic [DIV_BIT-1:0]  mult_next;
  logic                comb_step;
  logic                comb_mute;

  // Odd/even slope is chosen by the index the step will produce.
  assign step_sel = next_idx[0] ? i_Scale_Odd : i_Scale_Even;

`ifdef HARM_SCALE_EXP_EN
  logic [2*DIV_BIT-1:0] prod;
  logic [2*DIV_BIT-1:0] p_wide;
  logic [2*DIV_BIT-1:0] p_q;

  // Fractional attenuation: P = (mult * S) >> DIV_BIT, registered in ST_MUL.
  assign prod    = {{DIV_BIT{1'b0}}, o_Mult} * {{DIV_BIT{1'b0}}, step_sel};
  assign p_wide  = prod >> DIV_BIT;
  // At least 1 is subtracted so the decay always reaches zero.
  assign sub_amt = (p_q == '0) ? DIV_BIT'(1) : p_q[DIV_BIT-1:0];
`else
  // Linear decay: subtract the selected step directly.
  assign sub_amt = step_sel;
`endif

  // New multiplier candidate, clamped at zero.
  assign mult_next = DIV_BIT'(sat_sub(SUB_BIT'(o_Mult), SUB_BIT'(sub_amt)));

  assign o_Exhausted = (o_Mult == '0);

  // The comb is evaluated exactly once per step, in ST_CALC.
  assign comb_step = (state == ST_CALC) && !i_Restart;

  harmonic_comb_ctr #(
    .COMB_BIT (COMB_BIT)
  ) u_comb (
    .i_Clock    (i_Clock),
    .i_Reset_n  (i_Reset_n),
    .i_Step     (comb_step),
    .i_Clear    (i_Restart),
    .i_Interval (i_Comb_Interval),
    .o_Mute     (comb_mute)
  );

  // State register.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= ST_READY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; restart returns to ST_READY from anywhere.
  always_comb begin
    state_next = state;
    if (i_Restart) begin
      state_next = ST_READY;
    end else begin
      case (state)
`ifdef HARM_SCALE_EXP_EN
        ST_READY: if (i_Start) state_next = ST_MUL;
        ST_MUL:   state_next = ST_CALC;
`else
        ST_READY: if (i_Start) state_next = ST_CALC;
        ST_MUL:   state_next = ST_READY;
`endif
        ST_CALC:  state_next = ST_DONE;
        ST_DONE:  state_next = ST_READY;
        default:  state_next = ST_READY;
      endcase
    end
  end

  // Datapath registers: latch the next index, apply the step, raise ready.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Mult       <= '0;
      o_Harmonic   <= '0;
      o_Comb_Muted <= 1'b0;
      o_Mult_Ready <= 1'b1;
      next_idx     <= '0;
`ifdef HARM_SCALE_EXP_EN
      p_q          <= '0;
`endif
    end else if (i_Restart) begin
      o_Mult       <= i_Initial;
      o_Harmonic   <= '0;
      o_Comb_Muted <= 1'b0;
      o_Mult_Ready <= 1'b1;
    end else begin
      case (state)
        ST_READY: begin
          if (i_Start) begin
            o_Mult_Ready <= 1'b0;
            o_Comb_Muted <= 1'b0;
            next_idx     <= (o_Harmonic == HARM_MAX) ? HARM_MAX
                                                     : o_Harmonic + 1'b1;
          end
        end
`ifdef HARM_SCALE_EXP_EN
        ST_MUL: begin
          p_q <= p_wide;
        end
`endif
        ST_CALC: begin
          o_Mult       <= mult_next;
          o_Harmonic   <= next_idx;
          o_Comb_Muted <= comb_mute;
        end
        ST_DONE: begin
          o_Mult_Ready <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_scale_seq.sv
// Directed self-checking bench for harmonic_scale_seq. Inputs are driven and
// outputs sampled on the falling clock edge. Honours HARM_SCALE_EXP_EN.
module tb_harmonic_scale_seq;

`ifdef HARM_SCALE_EXP_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       i_Clock;
  logic       i_Reset_n;
  logic       i_Restart;
  logic       i_Start;
  logic [7:0] i_Initial;
  logic [7:0] i_Scale_Odd;
  logic [7:0] i_Scale_Even;
  logic [7:0] i_Comb_Interval;
  logic [7:0] o_Mult;
  logic [7:0] o_Harmonic;
  logic       o_Comb_Muted;
  logic       o_Exhausted;
  logic       o_Mult_Ready;

  int checks = 0;
  int errors = 0;

  harmonic_scale_seq #(
    .DIV_BIT  (8),
    .HARM_BIT (8),
    .COMB_BIT (8)
  ) dut (
    .i_Clock         (i_Clock),
    .i_Reset_n       (i_Reset_n),
    .i_Restart       (i_Restart),
    .i_Start         (i_Start),
    .i_Initial       (i_Initial),
    .i_Scale_Odd     (i_Scale_Odd),
    .i_Scale_Even    (i_Scale_Even),
    .i_Comb_Interval (i_Comb_Interval),
    .o_Mult          (o_Mult),
    .o_Harmonic      (o_Harmonic),
    .o_Comb_Muted    (o_Comb_Muted),
    .o_Exhausted     (o_Exhausted),
    .o_Mult_Ready    (o_Mult_Ready)
  );

  // 10-unit clock.
  initial begin
    i_Clock = 1'b0;
    forever #5 i_Clock = ~i_Clock;
  end

  // Frame restart with new coefficients.
  task automatic do_restart(input int init, input int odd, input int even, input int comb);
    @(negedge i_Clock);
    i_Initial       = 8'(init);
    i_Scale_Odd     = 8'(odd);
    i_Scale_Even    = 8'(even);
    i_Comb_Interval = 8'(comb);
    i_Restart       = 1'b1;
    @(negedge i_Clock);
    i_Restart       = 1'b0;
  endtask

  // One Start pulse; checks that Ready stays low for exactly LAT cycles.
  task automatic do_step();
    int wait_cnt;
    int low_cnt;
    wait_cnt = 0;
    while (!o_Mult_Ready && wait_cnt < 20) begin
      wait_cnt++;
      @(negedge i_Clock);
    end
    if (!o_Mult_Ready) begin
      checks++; errors++;
      $display("[TB] FAIL step_ready_timeout: ready=%0b required=1", o_Mult_Ready);
    end
    i_Start = 1'b1;
    @(negedge i_Clock);
    i_Start = 1'b0;
    low_cnt = 0;
    while (!o_Mult_Ready && low_cnt < 10) begin
      low_cnt++;
      @(negedge i_Clock);
    end
    checks++;
    if (low_cnt !== LAT) begin
      errors++;
      $display("[TB] FAIL step_latency: ready low %0d cycles, required %0d", low_cnt, LAT);
    end
  endtask

  task automatic test_reset();
    i_Reset_n = 1'b0;
    #12;
    checks++;
    if ({o_Mult, o_Harmonic, o_Comb_Muted, o_Mult_Ready, o_Exhausted} !== {8'd0, 8'd0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_state: mult=%0d harm=%0d muted=%0b ready=%0b exh=%0b required 0 0 0 1 1",
               o_Mult, o_Harmonic, o_Comb_Muted, o_Mult_Ready, o_Exhausted);
    end
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
  endtask

`ifndef HARM_SCALE_EXP_EN
  task automatic test_linear();
    int exp_m[4] = '{190, 160, 150, 120};
    do_restart(200, 10, 30, 0);
    for (int i = 0; i < 4; i++) begin
      do_step();
      checks++;
      if (o_Mult !== 8'(exp_m[i]) || o_Harmonic !== 8'(i + 1) || o_Comb_Muted !== 1'b0) begin
        errors++;
        $display("[TB] FAIL linear_step%0d: mult=%0d harm=%0d muted=%0b required %0d %0d 0",
                 i, o_Mult, o_Harmonic, o_Comb_Muted, exp_m[i], i + 1);
      end
    end
  endtask

  task automatic test_exhaust();
    int exp_m[5] = '{15, 5, 0, 0, 0};
    do_restart(25, 10, 10, 0);
    for (int i = 0; i < 5; i++) begin
      do_step();
      checks++;
      if (o_Mult !== 8'(exp_m[i]) || o_Exhausted !== (i >= 2)) begin
        errors++;
        $display("[TB] FAIL exhaust_step%0d: mult=%0d exh=%0b required %0d %0b",
                 i, o_Mult, o_Exhausted, exp_m[i], (i >= 2));
      end
    end
  endtask
`else
  task automatic test_exp();
    int exp_m[4] = '{96, 72, 54, 41};
    do_restart(128, 64, 64, 0);
    for (int i = 0; i < 4; i++) begin
      do_step();
      checks++;
      if (o_Mult !== 8'(exp_m[i])) begin
        errors++;
        $display("[TB] FAIL exp_step%0d: mult=%0d required %0d", i, o_Mult, exp_m[i]);
      end
    end
    do_restart(10, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      do_step();
      checks++;
      if (o_Mult !== 8'(9 - i)) begin
        errors++;
        $display("[TB] FAIL exp_min_step%0d: mult=%0d required %0d", i, o_Mult, 9 - i);
      end
    end
  endtask
`endif

  task automatic test_comb();
    logic exp_mute[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_restart(200, 1, 1, 2);
    for (int i = 0; i < 6; i++) begin
      do_step();
      checks++;
      if (o_Comb_Muted !== exp_mute[i]) begin
        errors++;
        $display("[TB] FAIL comb_step%0d: muted=%0b required %0b", i, o_Comb_Muted, exp_mute[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int run;
    int max_run;
    int wait_cnt;
    int exp_steps;
    exp_steps = (12 + LAT) / (LAT + 1);
    run = 0;
    max_run = 0;
    do_restart(200, 1, 1, 0);
    i_Start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge i_Clock);
      if (!o_Mult_Ready) begin
        run++;
      end else begin
        if (run > max_run) max_run = run;
        run = 0;
      end
    end
    i_Start = 1'b0;
    wait_cnt = 0;
    while (!o_Mult_Ready && wait_cnt < 20) begin
      wait_cnt++;
      @(negedge i_Clock);
    end
    if (run > max_run) max_run = run;
    checks++;
    if (o_Harmonic !== 8'(exp_steps) || o_Mult !== 8'(200 - exp_steps)) begin
      errors++;
      $display("[TB] FAIL b2b_steps: harm=%0d mult=%0d required %0d %0d",
               o_Harmonic, o_Mult, exp_steps, 200 - exp_steps);
    end
    checks++;
    if (max_run !== LAT) begin
      errors++;
      $display("[TB] FAIL b2b_ready_low: longest low run=%0d required %0d", max_run, LAT);
    end
  endtask

  task automatic test_restart();
    do_restart(100, 5, 5, 0);
    do_step();
    checks++;
    if (o_Mult !== 8'd95 || o_Harmonic !== 8'd1) begin
      errors++;
      $display("[TB] FAIL restart_pre: mult=%0d harm=%0d required 95 1", o_Mult, o_Harmonic);
    end
    // Abort a step that is in ST_CALC.
    i_Start = 1'b1;
    @(negedge i_Clock);
    i_Start = 1'b0;
    repeat (LAT - 2) @(negedge i_Clock);
    i_Initial = 8'd77;
    i_Restart = 1'b1;
    @(negedge i_Clock);
    i_Restart = 1'b0;
    checks++;
    if (o_Mult !== 8'd77 || o_Harmonic !== 8'd0 || o_Mult_Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_calc: mult=%0d harm=%0d ready=%0b required 77 0 1",
               o_Mult, o_Harmonic, o_Mult_Ready);
    end
    repeat (3) @(negedge i_Clock);
    checks++;
    if (o_Mult !== 8'd77 || o_Harmonic !== 8'd0) begin
      errors++;
      $display("[TB] FAIL restart_calc_hold: mult=%0d harm=%0d required 77 0", o_Mult, o_Harmonic);
    end
    // Restart and Start together: start is dropped.
    do_step();
    i_Initial = 8'd60;
    i_Restart = 1'b1;
    i_Start   = 1'b1;
    @(negedge i_Clock);
    i_Restart = 1'b0;
    i_Start   = 1'b0;
    checks++;
    if (o_Mult !== 8'd60 || o_Harmonic !== 8'd0 || o_Mult_Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_start: mult=%0d harm=%0d ready=%0b required 60 0 1",
               o_Mult, o_Harmonic, o_Mult_Ready);
    end
    repeat (3) @(negedge i_Clock);
    checks++;
    if (o_Mult !== 8'd60 || o_Harmonic !== 8'd0 || o_Mult_Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_start_hold: mult=%0d harm=%0d ready=%0b required 60 0 1",
               o_Mult, o_Harmonic, o_Mult_Ready);
    end
  endtask

  task automatic test_saturation();
    do_restart(0, 0, 0, 0);
    for (int i = 0; i < 255; i++) do_step();
    checks++;
    if (o_Harmonic !== 8'd255) begin
      errors++;
      $display("[TB] FAIL harm_reach_max: harm=%0d required 255", o_Harmonic);
    end
    do_step();
    checks++;
    if (o_Harmonic !== 8'd255 || o_Mult !== 8'd0) begin
      errors++;
      $display("[TB] FAIL harm_saturate: harm=%0d mult=%0d required 255 0", o_Harmonic, o_Mult);
    end
  endtask

  // Test sequence.
  initial begin
    i_Reset_n       = 1'b0;
    i_Restart       = 1'b0;
    i_Start         = 1'b0;
    i_Initial       = '0;
    i_Scale_Odd     = '0;
    i_Scale_Even    = '0;
    i_Comb_Interval = '0;
    test_reset();
`ifndef HARM_SCALE_EXP_EN
    test_linear();
    test_exhaust();
`else
    test_exp();
`endif
    test_comb();
    test_back_to_back();
    test_restart();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
